ysyx_220066_wb_arbiter: RTL

Writeback-port arbiter between the memory, divider and multiplier result producers and the single register-file write port. Each producer hands its result over with a valid/ready handshake into a private one-entry slot. A per-cycle grant picks one full slot using fixed priority with optional anti-starvation aging, and drives a registered writeback/retire port. It replaces the ad-hoc block signals of the writeback stage with explicit backpressure.

---
 rtl/ysyx_220066_wb_pkg.sv | 22 ++
 rtl/ysyx_220066_wb_arbiter_if.sv | 39 +++
 rtl/ysyx_220066_wb_slot.sv | 84 ++++++++
 rtl/ysyx_220066_wb_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/ysyx_220066_wb_pkg.sv
// Shared types for the writeback arbiter: source codes and slot payload.
// Data/PC fields are WB_XLEN wide; the arbiter supports XLEN up to that.
package ysyx_220066_wb_pkg;

    localparam int WB_XLEN = 64;
    localparam int AGE_W   = 4;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_DIV  = 2'd1,
        SRC_MUL  = 2'd2,
        SRC_NONE = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
        logic [WB_XLEN-1:0] pc;
        logic               error;
    } wb_payload_t;

endpackage

// File: rtl/ysyx_220066_wb_arbiter_if.sv
// Producer handshakes and the registered writeback/retire port.
// slave = arbiter side, master = producers plus register-file side.
interface ysyx_220066_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            m_valid, m_ready, m_error;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data, m_pc;

    logic            d_valid, d_ready, d_error;
    logic [4:0]      d_rd;
    logic [XLEN-1:0] d_data, d_pc;

    logic            u_valid, u_ready, u_error;
    logic [4:0]      u_rd;
    logic [XLEN-1:0] u_data, u_pc;

    logic            wb_valid, wb_wen, wb_error;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data, wb_pc;
    logic [1:0]      wb_src;

    modport slave (
        input  m_valid, m_rd, m_data, m_pc, m_error,
        input  d_valid, d_rd, d_data, d_pc, d_error,
        input  u_valid, u_rd, u_data, u_pc, u_error,
        output m_ready, d_ready, u_ready,
        output wb_valid, wb_wen, wb_rd, wb_data, wb_pc, wb_error, wb_src
    );

    modport master (
        output m_valid, m_rd, m_data, m_pc, m_error,
        output d_valid, d_rd, d_data, d_pc, d_error,
        output u_valid, u_rd, u_data, u_pc, u_error,
        input  m_ready, d_ready, u_ready,
        input  wb_valid, wb_wen, wb_rd, wb_data, wb_pc, wb_error, wb_src
    );

endinterface

// File: rtl/ysyx_220066_wb_slot.sv
// One-entry result buffer with ready generation and starvation age.
// Age counter exists only when WB_ARB_AGING_EN is defined.
module ysyx_220066_wb_slot
    import ysyx_220066_wb_pkg::*;
`ifdef WB_ARB_AGING_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  wb_payload_t      in_payload,
    input  logic             grant,
    output logic             ready,
    output logic             full,
    output logic [AGE_W-1:0] age,
    output wb_payload_t      payload
);

    logic        full_q, full_d;
    wb_payload_t payload_q, payload_d;
    logic        fire;

    // A granted slot drains this cycle, so it can accept a reload.
    assign ready   = ~full_q | grant;
    assign fire    = in_valid & ready;
    assign full    = full_q;
    assign payload = payload_q;

    // Next slot contents: load on handshake, empty on grant otherwise.
    always_comb begin
        full_d    = full_q;
        payload_d = payload_q;
        if (fire) begin
            full_d    = 1'b1;
            payload_d = in_payload;
        end else if (grant) begin
            full_d = 1'b0;
        end
    end

    // Slot state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            full_q    <= full_d;
            payload_q <= payload_d;
        end
    end

`ifdef WB_ARB_AGING_EN
    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age_q, age_d;

    // Count lost arbitrations while full, saturating at the limit.
    always_comb begin
        age_d = age_q;
        if (grant || !full_q) begin
            age_d = '0;
        end else if (age_q != LIMIT) begin
            age_d = age_q + 1'b1;
        end
    end

    // Age register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age = age_q;
`else
    assign age = '0;
`endif

endmodule

// File: rtl/ysyx_220066_wb_arbiter.sv
// Writeback arbiter: mem/div/mul slots into one registered retire port.
// Define WB_ARB_AGING_EN to enable anti-starvation aging.
module ysyx_220066_wb_arbiter
    import ysyx_220066_wb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_220066_wb_arbiter_if.slave bus
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    wb_payload_t      in_pl [3];
    wb_payload_t      pl    [3];
    logic [AGE_W-1:0] age   [3];
    logic [2:0]       in_valid, ready, full, starved, cand, grant;

    assign in_valid = {bus.u_valid, bus.d_valid, bus.m_valid};

    assign in_pl[0] = '{rd: bus.m_rd, data: WB_XLEN'(bus.m_data),
                        pc: WB_XLEN'(bus.m_pc), error: bus.m_error};
    assign in_pl[1] = '{rd: bus.d_rd, data: WB_XLEN'(bus.d_data),
                        pc: WB_XLEN'(bus.d_pc), error: bus.d_error};
    assign in_pl[2] = '{rd: bus.u_rd, data: WB_XLEN'(bus.u_data),
                        pc: WB_XLEN'(bus.u_pc), error: bus.u_error};

    assign bus.m_ready = ready[0];
    assign bus.d_ready = ready[1];
    assign bus.u_ready = ready[2];

    for (genvar i = 0; i < 3; i++) begin : g_slot
        ysyx_220066_wb_slot
`ifdef WB_ARB_AGING_EN
            #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
        u_slot (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[i]),
            .in_payload (in_pl[i]),
            .grant      (grant[i]),
            .ready      (ready[i]),
            .full       (full[i]),
            .age        (age[i]),
            .payload    (pl[i])
        );

        // Ages are tied to zero without aging, so this folds away.
        assign starved[i] = full[i] & (age[i] == LIMIT);
    end

    // Starved slots all sit at the same saturated age, so the
    // highest-age rule reduces to fixed priority among them.
    assign cand  = (|starved) ? starved : full;
    assign grant = cand & (~cand + 3'd1);

    logic               wb_valid_q, wb_valid_d;
    logic               wb_wen_q, wb_wen_d;
    logic               wb_error_q, wb_error_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [WB_XLEN-1:0] wb_data_q, wb_data_d;
    logic [WB_XLEN-1:0] wb_pc_q, wb_pc_d;
    wb_src_e            wb_src_q, wb_src_d;
    wb_payload_t        sel;

    // Mux the granted slot onto the retire port; zeros when idle.
    always_comb begin
        sel      = '0;
        wb_src_d = SRC_NONE;
        unique case (1'b1)
            grant[0]: begin sel = pl[0]; wb_src_d = SRC_MEM; end
            grant[1]: begin sel = pl[1]; wb_src_d = SRC_DIV; end
            grant[2]: begin sel = pl[2]; wb_src_d = SRC_MUL; end
            default:  ;
        endcase
        wb_valid_d = |grant;
        wb_wen_d   = wb_valid_d & (sel.rd != 5'd0) & ~sel.error;
        wb_rd_d    = sel.rd;
        wb_data_d  = sel.data;
        wb_pc_d    = sel.pc;
        wb_error_d = sel.error;
    end

    // Retire port register, loaded every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_error_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            wb_src_q   <= SRC_NONE;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_error_q <= wb_error_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_wen   = wb_wen_q;
    assign bus.wb_error = wb_error_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = XLEN'(wb_data_q);
    assign bus.wb_pc    = XLEN'(wb_pc_q);
    assign bus.wb_src   = wb_src_q;

endmodule
